// File: rtl/clk_ss_gen_pkg.sv
// rtl/clk_ss_gen_pkg.sv - shared constants and state encoding for the slow-clock generator
package clk_ss_gen_pkg;

    localparam int DIV_W_DEF    = 25;
    localparam int DEF_HALF_DEF = 25000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_HIGH = HIGH,
        ST_LOW  = LOW
    } state_t;

endpackage

// File: rtl/clk_ss_gen_if.sv
// rtl/clk_ss_gen_if.sv - enable, config handshake and slow-clock outputs of clk_ss_gen
interface clk_ss_gen_if
    import clk_ss_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             clk_ss;
    logic             tick_ss;
    logic             running;

    modport master (
        output en, cfg_valid, cfg_half,
        input  cfg_ready, clk_ss, tick_ss, running
    );

    modport slave (
        input  en, cfg_valid, cfg_half,
        output cfg_ready, clk_ss, tick_ss, running
    );

endinterface

// File: rtl/clk_ss_gen.sv
// rtl/clk_ss_gen.sv - programmable 50% duty slow clock with tick strobe and glitch-free ratio changes
module clk_ss_gen
    import clk_ss_gen_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic         clk,
    input  logic         rst,
    clk_ss_gen_if.slave  ss
);

    localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEF_HALF_V = DIV_W'(DEF_HALF);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active_half;
    logic [DIV_W-1:0] staged;
    logic [DIV_W-1:0] last_cnt;
    logic             pending;
    logic             at_end;
    logic             apply;
    logic             accept;

    assign last_cnt = active_half - ONE;
    assign at_end   = (cnt == last_cnt);
    // Staged ratio only lands where a period starts: idle, or the last LOW cycle.
    assign apply    = pending && ((state == ST_IDLE) || ((state == ST_LOW) && at_end));
    assign accept   = ss.cfg_valid && ss.cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 1'b0;
            ss.cfg_ready <= 1'b1;
            staged       <= DEF_HALF_V;
        end else if (apply) begin
            pending      <= 1'b0;
            ss.cfg_ready <= 1'b1;
        end else if (accept) begin
            staged       <= (ss.cfg_half == '0) ? ONE : ss.cfg_half;
            pending      <= 1'b1;
            ss.cfg_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            active_half <= DEF_HALF_V;
            ss.clk_ss   <= 1'b0;
            ss.tick_ss  <= 1'b0;
            ss.running  <= 1'b0;
        end else begin
            ss.tick_ss <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ss.clk_ss <= 1'b0;
                    if (pending) active_half <= staged;
                    if (ss.en) begin
                        state      <= ST_HIGH;
                        ss.clk_ss  <= 1'b1;
                        ss.tick_ss <= 1'b1;
                        ss.running <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        ss.running <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (at_end) begin
                        cnt       <= '0;
                        state     <= ST_LOW;
                        ss.clk_ss <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ST_LOW: begin
                    if (at_end) begin
                        cnt <= '0;
                        if (pending) active_half <= staged;
                        if (ss.en) begin
                            state      <= ST_HIGH;
                            ss.clk_ss  <= 1'b1;
                            ss.tick_ss <= 1'b1;
                        end else begin
                            state      <= ST_IDLE;
                            ss.running <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ss.clk_ss  <= 1'b0;
                    ss.running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ss_gen.sv
// tb/tb_clk_ss_gen.sv - scoreboard bench for clk_ss_gen against a period-position reference model
module tb_clk_ss_gen;
    import clk_ss_gen_pkg::*;

    localparam int W    = 8;
    localparam int DEFH = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_ss_gen_if #(.DIV_W(W)) bus();

    clk_ss_gen #(.DIV_W(W), .DEF_HALF(DEFH)) dut (
        .clk (clk),
        .rst (rst),
        .ss  (bus.slave)
    );

    typedef struct packed {
        logic clk_ss;
        logic tick;
        logic running;
        logic ready;
    } exp_t;

    exp_t sb[$];
    exp_t exp_mon;
    exp_t act_mon;
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    bit   started = 1'b0;

    // Reference: position within the current period, 0 .. 2*half-1
    bit m_act;
    int m_pos;
    int m_half;
    bit m_pend;
    int m_staged;

    task automatic model_step(input logic r, input logic e, input logic v, input int h);
        bit accept;
        bit boundary;
        if (r) begin
            m_act = 0; m_pos = 0; m_half = DEFH; m_pend = 0; m_staged = 0;
        end else begin
            accept   = v && !m_pend;
            boundary = !m_act || (m_pos == 2 * m_half - 1);
            if (boundary) begin
                if (m_pend) begin
                    m_half = m_staged;
                    m_pend = 0;
                end
                m_act = e;
                m_pos = 0;
            end else begin
                m_pos++;
            end
            if (accept) begin
                m_staged = (h == 0) ? 1 : h;
                m_pend   = 1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic v, input int h);
        exp_t x;
        @(negedge clk);
        rst           = r;
        bus.en        = e;
        bus.cfg_valid = v;
        bus.cfg_half  = W'(h);
        model_step(r, e, v, h);
        x.clk_ss  = m_act && (m_pos < m_half);
        x.tick    = m_act && (m_pos == 0);
        x.running = m_act;
        x.ready   = !m_pend;
        sb.push_back(x);
        started = 1'b1;
    endtask

    // Idle until the next cycle's inputs land at the wanted period position.
    task automatic wait_pos(input int target, input logic e);
        int n;
        n = 0;
        while (!(m_act && m_pos == target) && n < 60) begin
            cyc(1'b0, e, 1'b0, 0);
            n++;
        end
        total++;
        if (n >= 60) begin
            bad++;
            $display("FAIL wait_pos target=%0d not reached, pos=%0d act=%0d", target, m_pos, m_act);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cycle++;
        if (started) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_empty cycle=%0d got nothing required an expected entry", cycle);
            end else begin
                exp_mon = sb.pop_front();
                act_mon = {bus.clk_ss, bus.tick_ss, bus.running, bus.cfg_ready};
                if (act_mon !== exp_mon) begin
                    bad++;
                    if (bad <= 40)
                        $display("FAIL outputs cycle=%0d clk_ss/tick/running/ready got=%b required=%b",
                                 cycle, act_mon, exp_mon);
                end
            end
        end
    end

    initial begin
        int en_r;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_half  = '0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (14) cyc(0, 1, 0, 0);

        // ratio change offered mid-HIGH, then back to 3
        wait_pos(1, 1);
        cyc(0, 1, 1, 5);
        repeat (25) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 3);
        repeat (20) cyc(0, 1, 0, 0);

        // en dropped on the second HIGH cycle
        wait_pos(1, 1);
        repeat (10) cyc(0, 0, 0, 0);

        // zero half-period clamps to one
        cyc(0, 0, 1, 0);
        repeat (10) cyc(0, 1, 0, 0);

        // config landing exactly on the LOW boundary
        cyc(0, 1, 1, 3);
        repeat (8) cyc(0, 1, 0, 0);
        wait_pos(2 * m_half - 1, 1);
        cyc(0, 1, 1, 4);
        repeat (24) cyc(0, 1, 0, 0);

        // reset mid-LOW with a pending config
        wait_pos(0, 1);
        cyc(0, 1, 1, 6);
        wait_pos(2 * m_half - 2, 1);
        cyc(1, 1, 0, 0);
        repeat (14) cyc(0, 1, 0, 0);

        en_r = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) en_r = !en_r;
            cyc(($urandom_range(0, 199) == 0), en_r[0],
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 6)));
        end

        @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain leftover=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_ss_gen.md
Name: clk_ss_gen

Overview:
- Generates the slow clock `clk_ss` and a companion tick strobe from the system clock.
- Feeds the LED water-light controller and the other slow-domain blocks directly.
- Half-period is runtime-programmable through a valid/ready config port; a new ratio takes effect only at a period boundary, so `clk_ss` never produces a runt pulse.
- Start/stop is graceful: the current period always completes.

Parameters:
- DIV_W, 25, width of half-period counter and config value.
- DEF_HALF, 25000, reset half-period in clk cycles (1 kHz `clk_ss` from 50 MHz; one LED step per second downstream).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  level; 1 = generate `clk_ss`, 0 = stop after current period.
- cfg_valid  input  1  new half-period offered.
- cfg_half  input  DIV_W  requested half-period in clk cycles.
- cfg_ready  output  1  1 = staging register free, cfg accepted on `cfg_valid && cfg_ready`.
- clk_ss  output  1  generated slow clock, registered, 50% duty.
- tick_ss  output  1  one-clk pulse coincident with each `clk_ss` rising edge.
- running  output  1  1 when state is not IDLE.

Behaviour:
- Single clock `clk`; reset is synchronous and active-high; name `rst`.
- Reset state: state=IDLE, clk_ss=0, tick_ss=0, running=0, cfg_ready=1, active_half=DEF_HALF, pending=0, cnt=0.
- All outputs are registered. `cfg_ready` = !pending, from a flop.

States:
- IDLE:
  - clk_ss=0.
  - If pending: active_half<=staged, pending<=0.
  - If en=1: next state HIGH, clk_ss<=1, tick_ss<=1, cnt<=0.
  - When pending is applied in the same cycle as en is seen, the first period uses the new value.
- HIGH:
  - cnt++.
  - At cnt==active_half-1: cnt<=0, state<=LOW, clk_ss<=0.
- LOW:
  - cnt++.
  - At cnt==active_half-1 (period boundary): cnt<=0.
  - If pending: active_half<=staged, pending<=0.
  - Then if en=1: state<=HIGH, clk_ss<=1, tick_ss<=1. Otherwise: state<=IDLE.
- tick_ss is 0 in every other cycle.
- Period = 2*active_half clk cycles. High phase = low phase = active_half cycles.
- Rising edge of clk_ss (and tick_ss) occurs 1 cycle after en is first sampled high in IDLE.

Config handshake:
- Accept on cfg_valid && cfg_ready: staged<=(cfg_half==0 ? 1 : cfg_half), pending<=1.
- cfg_half=0 is clamped to 1, giving period 2 and clk_ss toggling every cycle.
- A config accepted in a boundary cycle is NOT applied at that boundary; it applies at the next boundary, or the next IDLE cycle.
- While pending=1, further cfg_valid is held off (cfg_ready=0); the value is not overwritten.

Enable:
- en falling mid-period does not truncate; the period completes through LOW, then goes to IDLE.
- en re-rising before the boundary continues seamlessly with no gap.

Other rules:
- Counter compare is unsigned DIV_W-bit. active_half is never 0, so there is no wrap hazard.
- rst mid-period: the next cycle shows reset values. The staged config is discarded.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, HIGH=2'd1, LOW=2'd2.
  - default DEF_HALF and DIV_W constants for the slow-clock domain.
- No sub-module. The half-period counter and FSM are a single always block plus a config-staging block.

Test Plan:
1. DEF_HALF=3, rst 1 for 2 cycles, en=1 -> clk_ss 1 cycle after en sampled, pattern 111000 repeating; tick_ss high only on each first-1 cycle; running=1.
2. Running with half=3, accept cfg_half=5 mid-HIGH -> cfg_ready=0 next cycle; current period stays 3/3; next period 5/5; cfg_ready returns 1 at the boundary.
3. cfg_half=0 accepted in IDLE, then en=1 -> clk_ss toggles every cycle (10 repeating); tick_ss every 2nd cycle.
4. en dropped on the 2nd HIGH cycle (half=3) -> HIGH finishes 3 cycles, LOW 3 cycles, then IDLE, running=0, clk_ss stays 0, no tick.
5. cfg accepted exactly in the LOW boundary cycle with half=3, value 4 -> following period still 3/3, the one after is 4/4.
6. rst asserted mid-LOW with pending cfg -> next cycle clk_ss=0, running=0, cfg_ready=1; after en, period is DEF_HALF and the pending value is gone.
